// File: rtl/usb_host_pkg.sv
// usb_host_pkg: shared USB host encodings for line control, tx sequencing and rx connect state.
package usb_host_pkg;
  typedef enum logic [1:0] {
    LINE_SIE = 2'b00,
    LINE_SE0 = 2'b01,
    LINE_K   = 2'b10,
    LINE_J   = 2'b11
  } lineCtrl_t;
  typedef enum logic [2:0] {
    IDLE,
    RST_SE0,
    RES_K,
    RES_EOP_SE0,
    RES_EOP_J
  } txState_t;
  typedef enum logic [1:0] {
    CONN_DISCONNECT = 2'b00,
    CONN_LOW_SPEED  = 2'b01,
    CONN_FULL_SPEED = 2'b10
  } connState_t;
  function automatic lineCtrl_t lineOf(txState_t s);
    return (s == RST_SE0 || s == RES_EOP_SE0) ? LINE_SE0 :
           (s == RES_K)                       ? LINE_K   :
           (s == RES_EOP_J)                   ? LINE_J   : LINE_SIE;
  endfunction
endpackage

// File: rtl/usb_dur_counter.sv
// usb_dur_counter: loadable down-counter that parks at zero instead of wrapping.
module usb_dur_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] loadVal,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else if (load) count <= loadVal;
    else if (en && !zero) count <= count - 1'b1;
  end
  assign zero = (count == '0);
endmodule

// File: rtl/usb_tx_line_signal_ctrl.sv
// usb_tx_line_signal_ctrl: takes the line from the SIE to drive timed bus reset and resume signalling.
module usb_tx_line_signal_ctrl
  import usb_host_pkg::*;
#(
  parameter int CLK_PER_US   = 48,
  parameter int RESET_US     = 10000,
  parameter int RESUME_US    = 20000,
  parameter int EOP_SE0_CLKS = 64,
  parameter int EOP_J_CLKS   = 32,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sendResetReq,
  input  logic       sendResumeReq,
  input  logic       disconnectIn,
  output logic [1:0] lineCtrlOut,
  output logic       forceOeOut,
  output logic       busyOut,
  output logic       doneOut,
  output logic       abortOut
);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] RES_LOAD = CNT_W'(RESUME_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] SE0_LOAD = CNT_W'(EOP_SE0_CLKS - 1);
  localparam logic [CNT_W-1:0] J_LOAD   = CNT_W'(EOP_J_CLKS - 1);

  txState_t         state, nextState;
  logic             load, zero, doneNext, abortNext;
  logic [CNT_W-1:0] loadVal, count;

  usb_dur_counter #(.CNT_W(CNT_W)) durCnt (
    .clk(clk), .rst(rst), .load(load), .en(state != IDLE),
    .loadVal(loadVal), .count(count), .zero(zero)
  );

  always_comb begin
    nextState = state;
    load      = 1'b0;
    loadVal   = '0;
    doneNext  = 1'b0;
    abortNext = 1'b0;
    if (state == IDLE) begin
      if (!disconnectIn && sendResetReq) begin
        nextState = RST_SE0;
        load      = 1'b1;
        loadVal   = RST_LOAD;
      end else if (!disconnectIn && sendResumeReq) begin
        nextState = RES_K;
        load      = 1'b1;
        loadVal   = RES_LOAD;
      end
    end else if (disconnectIn) begin
      nextState = IDLE;
      abortNext = 1'b1;
    end else if (zero) begin
      case (state)
        RES_K: begin
          nextState = RES_EOP_SE0;
          load      = 1'b1;
          loadVal   = SE0_LOAD;
        end
        RES_EOP_SE0: begin
          nextState = RES_EOP_J;
          load      = 1'b1;
          loadVal   = J_LOAD;
        end
        default: begin
          nextState = IDLE;
          doneNext  = 1'b1;
        end
      endcase
    end
  end

  // Outputs follow the next state so every pin changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lineCtrlOut <= LINE_SIE;
      forceOeOut  <= 1'b0;
      busyOut     <= 1'b0;
      doneOut     <= 1'b0;
      abortOut    <= 1'b0;
    end else begin
      state       <= nextState;
      lineCtrlOut <= lineOf(nextState);
      forceOeOut  <= (nextState != IDLE);
      busyOut     <= (nextState != IDLE);
      doneOut     <= doneNext;
      abortOut    <= abortNext;
    end
  end
endmodule

// File: tb/tb_usb_tx_line_signal_ctrl.sv
// tb_usb_tx_line_signal_ctrl: directed and random stimulus checked against a queue-of-line-values model.
module tb_usb_tx_line_signal_ctrl;
  logic       clk = 0;
  logic       rst = 0;
  logic       sendResetReq = 0, sendResumeReq = 0, disconnectIn = 0;
  logic [1:0] lineCtrlOut;
  logic       forceOeOut, busyOut, doneOut, abortOut;

  int nChecks = 0;
  int nFails = 0;

  logic [1:0] expQ[$];
  logic       mBusy = 0;
  logic [1:0] expLine = 0;
  logic       expDone = 0, expAbort = 0;

  usb_tx_line_signal_ctrl #(
    .CLK_PER_US(4), .RESET_US(5), .RESUME_US(3), .EOP_SE0_CLKS(8), .EOP_J_CLKS(4), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst), .sendResetReq(sendResetReq), .sendResumeReq(sendResumeReq),
    .disconnectIn(disconnectIn), .lineCtrlOut(lineCtrlOut), .forceOeOut(forceOeOut),
    .busyOut(busyOut), .doneOut(doneOut), .abortOut(abortOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushSeg(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) expQ.push_back(v);
  endtask

  task automatic modelReset();
    expQ.delete();
    mBusy = 0; expLine = 0; expDone = 0; expAbort = 0;
  endtask

  // Model view: a sequence is just the list of line values it shows, one per cycle.
  task automatic modelEdge();
    expDone = 0; expAbort = 0;
    if (!rst) begin
      modelReset();
    end else if (!mBusy) begin
      if (!disconnectIn && (sendResetReq || sendResumeReq)) begin
        if (sendResetReq) pushSeg(2'b01, 20);
        else begin
          pushSeg(2'b10, 12); pushSeg(2'b01, 8); pushSeg(2'b11, 4);
        end
        mBusy = 1;
        expLine = expQ.pop_front();
      end
    end else if (disconnectIn) begin
      expQ.delete(); mBusy = 0; expLine = 0; expAbort = 1;
    end else if (expQ.size() == 0) begin
      mBusy = 0; expLine = 0; expDone = 1;
    end else begin
      expLine = expQ.pop_front();
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".line"}, 8'(lineCtrlOut), 8'(expLine));
    check({tag, ".oe"}, 8'(forceOeOut), 8'(expLine != 0));
    check({tag, ".busy"}, 8'(busyOut), 8'(mBusy));
    check({tag, ".done"}, 8'(doneOut), 8'(expDone));
    check({tag, ".abort"}, 8'(abortOut), 8'(expAbort));
  endtask

  task automatic step(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkAll(tag);
      sendResetReq = 0; sendResumeReq = 0;
    end
  endtask

  int doneCnt, lineCnt;

  initial begin
    step("rst", 2);
    rst = 1;
    step("idle", 2);
    // single reset: count SE0 cycles and done pulses independently of the model
    sendResetReq = 1;
    lineCnt = 0; doneCnt = 0;
    for (int i = 0; i < 25; i++) begin
      step("t1", 1);
      if (lineCtrlOut == 2'b01) lineCnt++;
      if (doneOut) doneCnt++;
    end
    check("t1.se0Len", 8'(lineCnt), 8'd20);
    check("t1.doneCnt", 8'(doneCnt), 8'd1);
    sendResumeReq = 1;
    lineCnt = 0;
    for (int i = 0; i < 28; i++) begin
      step("t2", 1);
      if (forceOeOut) lineCnt++;
    end
    check("t2.oeLen", 8'(lineCnt), 8'd24);
    sendResetReq = 1; sendResumeReq = 1;
    step("t3a", 5);
    sendResumeReq = 1;
    step("t3b", 22);
    sendResumeReq = 1;
    step("t4a", 6);
    disconnectIn = 1;
    step("t4a", 1);
    disconnectIn = 0;
    step("t4a", 3);
    sendResetReq = 1;
    step("t4b", 20);
    disconnectIn = 1;
    step("t4b", 1);
    disconnectIn = 0;
    step("t4b", 3);
    sendResetReq = 1;
    step("t5", 10);
    rst = 0;
    #1;
    modelReset();
    checkAll("t5.async");
    step("t5.hold", 2);
    rst = 1;
    sendResetReq = 1;
    step("t5.rerun", 24);
    disconnectIn = 1; sendResetReq = 1;
    step("t6", 3);
    disconnectIn = 0;
    step("t6", 1);
    for (int i = 0; i < 4000; i++) begin
      sendResetReq  = ($urandom_range(0, 15) == 0);
      sendResumeReq = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) disconnectIn = ~disconnectIn;
      step("rand", 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/usb_tx_line_signal_ctrl.md
Name: usb_tx_line_signal_ctrl

Overview:
Host-side transmit counterpart to the receive status monitor. On request it takes control of the USB line from the SIE and drives timed bus signalling: bus reset (SE0) and resume (K, then low-speed EOP). Sits between the host controller register/control logic and the SIE transmit mux. Reports busy, completion and abort.

Parameters:
CLK_PER_US, 48, clk cycles per microsecond (48 MHz default).
RESET_US, 10000, bus reset SE0 duration in us.
RESUME_US, 20000, resume K duration in us.
EOP_SE0_CLKS, 64, EOP SE0 length in clk cycles (2 LS bit times at 48 MHz).
EOP_J_CLKS, 32, trailing J length in clk cycles (1 LS bit time).
CNT_W, 20, duration counter width; must hold max(RESET_US,RESUME_US)*CLK_PER_US-1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sendResetReq  in  1  1-cycle pulse: start bus reset
sendResumeReq  in  1  1-cycle pulse: start resume signalling
disconnectIn  in  1  level: device disconnected (connect state == disconnect); aborts operation
lineCtrlOut  out  2  00 SIE drives line, 01 force SE0, 10 force K, 11 force J
forceOeOut  out  1  1 while lineCtrlOut != 00
busyOut  out  1  1 while any sequence active
doneOut  out  1  1-cycle pulse on normal completion
abortOut  out  1  1-cycle pulse on abort

Behaviour:
- Reset (rst low, async): state IDLE, counter 0, lineCtrlOut 00, forceOeOut 0, busyOut 0, doneOut 0, abortOut 0. Release is synchronous to clk.
- All outputs registered; no combinational input-to-output path.
- States: IDLE, RST_SE0, RES_K, RES_EOP_SE0, RES_EOP_J.
- IDLE: on edge sampling sendResetReq=1 and disconnectIn=0 -> RST_SE0, counter loads RESET_US*CLK_PER_US-1, lineCtrlOut 01. Otherwise on sendResumeReq=1 and disconnectIn=0 -> RES_K, counter loads RESUME_US*CLK_PER_US-1, lineCtrlOut 10. Both requests high: reset wins, resume dropped. Request with disconnectIn=1: ignored, no pulses.
- Active states: counter decrements each cycle; each state's lineCtrlOut value holds exactly N cycles (N = loaded value + 1). When counter==0:
  - RST_SE0 -> IDLE, doneOut pulses.
  - RES_K -> RES_EOP_SE0 (load EOP_SE0_CLKS-1, lineCtrlOut 01).
  - RES_EOP_SE0 -> RES_EOP_J (load EOP_J_CLKS-1, lineCtrlOut 11).
  - RES_EOP_J -> IDLE, doneOut pulses.
- On every return to IDLE, lineCtrlOut 00 and busyOut 0 on the same edge that sets doneOut/abortOut.
- busyOut = 1 in every non-IDLE state; forceOeOut = (lineCtrlOut != 00).
- Requests while busy are ignored, not queued.
- disconnectIn=1 in any active state: next edge -> IDLE, lineCtrlOut 00, abortOut pulses, doneOut stays 0. Abort wins over a simultaneous counter==0.
- Async reset mid-sequence: immediate return to reset values; no done/abort pulse.
- Counter never wraps: it is only loaded on entry and is not decremented in IDLE.

Decomposition:
- Shared package usb_host_pkg: line-control encodings (LINE_SIE, LINE_SE0, LINE_K, LINE_J) and the state enum. The rx status monitor's connect-state encodings, used to derive disconnectIn upstream, also go here.
- One natural sub-module: usb_dur_counter, a loadable down-counter of width CNT_W with load and zero flag. Everything else lives in the top FSM.

Test Plan:
(Bench params: CLK_PER_US=4, RESET_US=5, RESUME_US=3, EOP_SE0_CLKS=8, EOP_J_CLKS=4.)
1. Pulse sendResetReq -> lineCtrlOut=01 for exactly 20 cycles, busyOut=1 for the same 20 cycles, then lineCtrlOut=00 and doneOut=1 for 1 cycle.
2. Pulse sendResumeReq -> lineCtrlOut 10 for 12 cycles, then 01 for 8, then 11 for 4, then 00 with doneOut pulse; forceOeOut=1 for all 24 cycles.
3. sendResetReq and sendResumeReq in the same cycle -> only the 20-cycle SE0 sequence runs. A sendResumeReq pulse at cycle 5 of a reset -> ignored; no second sequence.
4. Start resume; set disconnectIn=1 at cycle 6 -> next edge lineCtrlOut=00, busyOut=0, abortOut=1 for 1 cycle, doneOut never asserts. disconnectIn=1 coincident with the last SE0 cycle of a reset -> abortOut only.
5. Start reset; drive rst low at cycle 10 -> outputs go to reset values immediately, before any clk edge. After release, IDLE with no pulses, and a new sendResetReq runs the full 20 cycles.
6. sendResetReq while disconnectIn=1 -> no state change, all outputs remain 0.
